// File: rtl/crc32_stream.sv
// crc32_stream: streaming Ethernet CRC-32 engine, NB byte lanes per beat,
// partial last beat via keep, result held on a valid/ready handshake.
module crc32_stream #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DATA_W-1:0]   s_data,
  input  logic [DATA_W/8-1:0] s_keep,
  input  logic                s_last,
  input  logic                s_abort,
  output logic                crc_valid,
  input  logic                crc_ready,
  output logic [31:0]         crc_value,
  output logic                crc_ok,
  output logic [LEN_W-1:0]    frame_len
);
  localparam int NB = DATA_W / 8;
  localparam logic [31:0] INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] POLY    = 32'hEDB8_8320;
  localparam logic [31:0] RESIDUE = 32'hDEBB_20E3;
  localparam logic [0:0]  ACCUM   = 1'b0;
  localparam logic [0:0]  RESULT  = 1'b1;

  logic [0:0]       state_q;
  logic [31:0]      crc_q;
  logic [31:0]      crc_nx;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_nx;
  logic [LEN_W:0]   add;
  logic [LEN_W:0]   sum;

  function automatic logic [31:0] crc_byte(
    input logic [31:0] c,
    input logic [7:0]  b
  );
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int k = 0; k < 8; k++)
      r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
    return r;
  endfunction

  // Lane 0 is earliest on the wire; keep only gates the last beat.
  always_comb begin
    crc_nx = crc_q;
    add    = '0;
    for (int i = 0; i < NB; i++) begin
      if (!s_last || s_keep[i]) begin
        crc_nx = crc_byte(crc_nx, s_data[8*i +: 8]);
        add    = add + (LEN_W+1)'(1);
      end
    end
    sum    = {1'b0, len_q} + add;
    len_nx = sum[LEN_W] ? '1 : sum[LEN_W-1:0];
  end

  assign s_ready   = (state_q == ACCUM);
  assign crc_valid = (state_q == RESULT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACCUM;
      crc_q     <= INIT;
      len_q     <= '0;
      crc_value <= '0;
      crc_ok    <= 1'b0;
      frame_len <= '0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (s_abort) begin
            crc_q <= INIT;
            len_q <= '0;
          end else if (s_valid) begin
            crc_q <= crc_nx;
            len_q <= len_nx;
            if (s_last) begin
              state_q   <= RESULT;
              crc_value <= ~crc_nx;
              crc_ok    <= (crc_nx == RESIDUE);
              frame_len <= len_nx;
            end
          end
        end
        RESULT: begin
          if (crc_ready) begin
            state_q <= ACCUM;
            crc_q   <= INIT;
            len_q   <= '0;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end
endmodule

// File: tb/tb_crc32_stream.sv
// tb_crc32_stream: four engines (8/16/32/64-bit) against a table-driven
// CRC-32 model; expected results queued, popped by a monitor.
module tb_crc32_stream;
  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [31:0] crc;
    logic        ok;
    logic [15:0] len;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  s_valid = '0;
  logic [3:0]  s_last = '0;
  logic [3:0]  s_abort = '0;
  logic [3:0]  crc_ready = 4'hF;
  logic [3:0]  s_ready;
  logic [3:0]  crc_valid;
  logic [3:0]  crc_ok;
  logic [63:0] s_data[4];
  logic [7:0]  s_keep[4];
  logic [31:0] crc_value[4];
  logic [15:0] frame_len[4];

  int n_cmp = 0;
  int n_bad = 0;
  int rdy_mode = 0;
  exp_t q[$];
  logic [31:0] tbl[256];
  logic [3:0] hold_v = '0;
  exp_t hold_e[4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : gen_dut
    localparam int W = 8 << g;
    crc32_stream #(.DATA_W(W), .LEN_W(16)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .s_valid   (s_valid[g]),
      .s_ready   (s_ready[g]),
      .s_data    (s_data[g][W-1:0]),
      .s_keep    (s_keep[g][W/8-1:0]),
      .s_last    (s_last[g]),
      .s_abort   (s_abort[g]),
      .crc_valid (crc_valid[g]),
      .crc_ready (crc_ready[g]),
      .crc_value (crc_value[g]),
      .crc_ok    (crc_ok[g]),
      .frame_len (frame_len[g])
    );
  end

  function automatic void chk(string nm, logic [63:0] act,
                              logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic exp_t mk(logic [31:0] c, logic o, logic [15:0] l);
    exp_t e;
    e.crc = c;
    e.ok  = o;
    e.len = l;
    return e;
  endfunction

  // Byte-table CRC-32 over the whole frame.
  function automatic exp_t model(bq_t b);
    logic [31:0] c;
    exp_t e;
    c = 32'hFFFF_FFFF;
    foreach (b[i]) c = (c >> 8) ^ tbl[c[7:0] ^ b[i]];
    e.crc = ~c;
    e.ok  = (c == 32'hDEBB_20E3);
    e.len = (b.size() > 65535) ? 16'hFFFF : 16'(b.size());
    return e;
  endfunction

  function automatic bq_t str9();
    bq_t b;
    for (int i = 0; i < 9; i++) b.push_back(8'(8'h31 + i));
    return b;
  endfunction

  always @(posedge clk) begin
    #2;
    if (rdy_mode == 1)
      crc_ready = ($urandom_range(0, 1) == 1) ? 4'hF : 4'h0;
    else if (rdy_mode == 0)
      crc_ready = 4'hF;
  end

  always @(negedge clk) begin
    for (int g = 0; g < 4; g++) begin
      exp_t a;
      exp_t e;
      a = {crc_value[g], crc_ok[g], frame_len[g]};
      if (crc_valid[g] && hold_v[g])
        chk($sformatf("hold g%0d", g), a, hold_e[g]);
      if (crc_valid[g] && crc_ready[g]) begin
        hold_v[g] = 1'b0;
        if (q.size() == 0) begin
          chk($sformatf("extra result g%0d", g), a, 0);
        end else begin
          e = q.pop_front();
          chk($sformatf("crc g%0d", g), a.crc, e.crc);
          chk($sformatf("ok g%0d", g), a.ok, e.ok);
          chk($sformatf("len g%0d", g), a.len, e.len);
        end
      end else begin
        hold_v[g] = crc_valid[g];
        hold_e[g] = a;
      end
    end
  end

  task automatic set_rdy(input logic v);
    @(posedge clk);
    #1;
    crc_ready = {4{v}};
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 2000; t++) begin
      if (crc_valid == 4'h0 && q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain", q.size(), 0);
  endtask

  // Returns on the negedge after the last beat is accepted.
  task automatic drive_frame(input int g, input bq_t b,
                             input bit et, input bit bp);
    int nb;
    int n;
    int nbeats;
    int pos;
    int t;
    logic [63:0] d;
    logic [7:0] kp;
    nb = 1 << g;
    n = b.size();
    pos = 0;
    nbeats = (n + nb - 1) / nb;
    if (nbeats == 0 || et) nbeats++;
    @(negedge clk);
    for (int k = 0; k < nbeats; k++) begin
      if (bp) begin
        s_valid[g] = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      d = {$urandom, $urandom};
      kp = '0;
      for (int j = 0; j < nb; j++) begin
        if (pos < n) begin
          d[8*j +: 8] = b[pos];
          kp[j] = 1'b1;
          pos++;
        end
      end
      s_data[g] = d;
      s_last[g] = (k == nbeats - 1);
      s_keep[g] = s_last[g] ? kp : 8'($urandom);
      s_valid[g] = 1'b1;
      t = 0;
      while (!s_ready[g] && t < 2000) begin
        @(negedge clk);
        t++;
      end
      chk($sformatf("accept g%0d", g), s_ready[g], 1);
      @(posedge clk);
      @(negedge clk);
    end
    s_valid[g] = 1'b0;
    s_last[g] = 1'b0;
  endtask

  initial begin
    bq_t b;
    bq_t c;
    int n;
    bit et;
    for (int i = 0; i < 256; i++) begin
      logic [31:0] v;
      v = 32'(i);
      for (int k = 0; k < 8; k++)
        v = v[0] ? ((v >> 1) ^ 32'hEDB8_8320) : (v >> 1);
      tbl[i] = v;
    end
    for (int g = 0; g < 4; g++) begin
      s_data[g] = '0;
      s_keep[g] = '0;
    end

    repeat (3) @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("rst s_ready g%0d", g), s_ready[g], 1);
      chk($sformatf("rst valid g%0d", g), crc_valid[g], 0);
      chk($sformatf("rst crc g%0d", g), crc_value[g], 0);
      chk($sformatf("rst ok g%0d", g), crc_ok[g], 0);
      chk($sformatf("rst len g%0d", g), frame_len[g], 0);
    end
    rst = 1'b0;

    for (int g = 0; g < 4; g++) begin
      q.push_back(mk(32'hCBF4_3926, 1'b0, 16'd9));
      drive_frame(g, str9(), 1'b0, 1'b0);
      chk($sformatf("latency g%0d", g), crc_valid[g], 1);
      wait_idle();
    end

    b = str9();
    b.push_back(8'h26);
    b.push_back(8'h39);
    b.push_back(8'hF4);
    b.push_back(8'hCB);
    q.push_back(mk(32'h2144_DF1C, 1'b1, 16'd13));
    drive_frame(0, b, 1'b0, 1'b0);
    for (int r = 0; r < 4; r++) begin
      c = b;
      n = $urandom_range(0, 12);
      c[n] = c[n] ^ 8'(1 << $urandom_range(0, 7));
      q.push_back(model(c));
      drive_frame(r, c, 1'b0, 1'b0);
    end
    b = {};
    b.push_back(8'h00);
    q.push_back(mk(32'hD202_EF8D, 1'b0, 16'd1));
    drive_frame(0, b, 1'b0, 1'b0);
    b = {};
    q.push_back(mk(32'h0000_0000, 1'b0, 16'd0));
    drive_frame(0, b, 1'b0, 1'b0);
    q.push_back(mk(32'h0000_0000, 1'b0, 16'd0));
    drive_frame(3, b, 1'b0, 1'b0);
    wait_idle();

    rdy_mode = 2;
    set_rdy(1'b0);
    q.push_back(mk(32'hCBF4_3926, 1'b0, 16'd9));
    drive_frame(2, str9(), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("hold valid", crc_valid[2], 1);
      chk("hold s_ready", s_ready[2], 0);
      @(negedge clk);
    end
    set_rdy(1'b1);
    rdy_mode = 0;
    q.push_back(mk(32'hCBF4_3926, 1'b0, 16'd9));
    drive_frame(2, str9(), 1'b0, 1'b0);
    wait_idle();

    @(negedge clk);
    s_valid[2] = 1'b1;
    s_last[2] = 1'b0;
    s_data[2] = 64'hDEAD_BEEF;
    s_keep[2] = 8'hF;
    @(negedge clk);
    s_abort[2] = 1'b1;
    s_last[2] = 1'b1;
    s_data[2] = 64'h1234_5678;
    @(negedge clk);
    s_abort[2] = 1'b0;
    s_valid[2] = 1'b0;
    s_last[2] = 1'b0;
    q.push_back(mk(32'hCBF4_3926, 1'b0, 16'd9));
    drive_frame(2, str9(), 1'b0, 1'b0);
    wait_idle();

    rdy_mode = 2;
    set_rdy(1'b0);
    q.push_back(mk(32'hCBF4_3926, 1'b0, 16'd9));
    drive_frame(1, str9(), 1'b0, 1'b0);
    s_abort[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    s_abort[1] = 1'b0;
    set_rdy(1'b1);
    @(negedge clk);
    wait_idle();

    set_rdy(1'b0);
    b = str9();
    b.push_back(8'hAA);
    drive_frame(0, b, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst result valid", crc_valid[0], 0);
    chk("rst result s_ready", s_ready[0], 1);
    chk("rst result crc", crc_value[0], 0);
    rst = 1'b0;
    set_rdy(1'b1);
    rdy_mode = 0;
    q.push_back(mk(32'hCBF4_3926, 1'b0, 16'd9));
    drive_frame(0, str9(), 1'b0, 1'b0);
    wait_idle();

    b = {};
    for (int i = 0; i < 65600; i++) b.push_back(8'($urandom));
    q.push_back(model(b));
    drive_frame(3, b, 1'b0, 1'b0);
    wait_idle();

    for (int g = 0; g < 4; g++) begin
      rdy_mode = 1;
      for (int f = 0; f < 200; f++) begin
        b = {};
        n = $urandom_range(0, 3 * (1 << g) + 6);
        for (int i = 0; i < n; i++) b.push_back(8'($urandom));
        et = (n > 0) && (n % (1 << g) == 0)
             && ($urandom_range(0, 2) == 0);
        q.push_back(model(b));
        drive_frame(g, b, et, 1'b1);
      end
      rdy_mode = 0;
      wait_idle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/crc32_stream.md
Name: crc32_stream

Overview:
- Streaming Ethernet CRC-32 engine with parametrised datapath width (1, 2, 4 or 8 bytes per beat).
- Accumulates a frame over valid/ready beats, handles a partial final beat via byte-keep, and presents the FCS, an FCS-check flag and the frame byte count on a held result handshake.
- Sits between the MAC byte/word stream and the TX FCS inserter / RX frame checker, replacing per-byte combinational CRC instances.

Parameters:
- DATA_W, 8, beat width in bits; legal values 8, 16, 32, 64. Lanes NB = DATA_W/8.
- LEN_W, 16, width of the frame byte counter.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- s_valid  in  1  input beat valid
- s_ready  out  1  engine accepts a beat this cycle
- s_data  in  DATA_W  beat data; lane 0 = s_data[7:0] is the earliest byte on the wire
- s_keep  in  NB  lane valid mask, used on the last beat only
- s_last  in  1  beat ends the frame
- s_abort  in  1  discard the frame in progress
- crc_valid  out  1  result available
- crc_ready  in  1  downstream takes the result
- crc_value  out  32  final FCS = ~register
- crc_ok  out  1  register equals residue 0xDEBB20E3 (frame including FCS is good)
- frame_len  out  LEN_W  bytes processed in the frame, saturating at all-ones

Behaviour:
- CRC definition: poly 0x04C11DB7, reflected form 0xEDB88320, LSB-first per byte, init 0xFFFFFFFF, final XOR 0xFFFFFFFF.
- Within a beat, lanes are processed 0 to NB-1 in a single cycle as an unrolled chain of byte updates.
- FSM, two states:
  - ACCUM: s_ready=1, crc_valid=0.
  - RESULT: s_ready=0, crc_valid=1.
- Reset: state ACCUM, register 0xFFFFFFFF, length counter 0. Outputs: s_ready=1, crc_valid=0, crc_value=0, crc_ok=0, frame_len=0.
- ACCUM, beat accepted (s_valid & s_ready), s_last=0: all NB lanes are folded in; s_keep is ignored; counter += NB (saturating).
- ACCUM, beat accepted, s_last=1:
  - Only lanes with s_keep=1 are folded in. s_keep must be contiguous from lane 0; non-contiguous masks are illegal and the result is unspecified.
  - Counter += popcount(keep).
  - Next cycle the FSM is in RESULT. crc_value, crc_ok and frame_len are registered from the post-beat state, so latency is 1 cycle from last-beat acceptance to crc_valid.
- s_last with s_keep=0: no bytes are folded in. The result reflects the previously accumulated bytes; an empty frame gives crc_value 0x00000000.
- RESULT: crc_value, crc_ok and frame_len stay stable while crc_valid=1 and crc_ready=0. When crc_ready=1:
  - next cycle the FSM returns to ACCUM;
  - the register reloads 0xFFFFFFFF and the counter clears;
  - crc_valid drops. crc_value, crc_ok and frame_len keep their last values but are don't-care while crc_valid=0.
  - Minimum frame-to-frame gap is 1 cycle: s_ready is low in RESULT.
- s_abort in ACCUM: the register reloads init and the counter clears next cycle, with no result. An abort takes priority over a beat accepted in the same cycle, and that beat is dropped.
- s_abort in RESULT: ignored; the pending result must still be consumed.
- rst asserted at any point, including mid-frame or in RESULT: returns to reset values next edge, and any pending result is lost.
- frame_len saturates at 2^LEN_W-1 and never wraps.
- crc_ok is evaluated on the raw register before the final XOR. It is meaningful when the received FCS bytes are included in the stream.

Test Plan:
- DATA_W=8, bytes "123456789" (0x31..0x39), last on 0x39, keep=1 -> crc_value=0xCBF43926, frame_len=9, crc_ok=0; crc_valid exactly 1 cycle after the last beat.
- DATA_W=32, beats 0x34333231, 0x38373635, 0x00000039 with keep=0001 and last -> crc_value=0xCBF43926, frame_len=9; repeat with DATA_W=64, keep=0x01 on beat 2 -> same result.
- Check mode, DATA_W=8: "123456789" followed by 0x26, 0x39, 0xF4, 0xCB -> crc_ok=1, crc_value=0x2144DF1C, frame_len=13. Flip one bit of any byte -> crc_ok=0.
- Single byte 0x00 -> 0xD202EF8D. Empty frame (first beat last, keep=0) -> 0x00000000, frame_len=0. Hold crc_ready=0 for 5 cycles -> outputs stable and s_ready=0 throughout; the following frame's CRC is correct, i.e. the register reloaded.
- Random s_valid/crc_ready backpressure over 200 random frames at each DATA_W, with random final keep -> matches a software CRC-32 model and byte count.
- Assert s_abort mid-frame, then send "123456789" -> 0xCBF43926. Assert rst in RESULT -> crc_valid=0 and s_ready=1 next cycle.
